// File: rtl/mips_data_mem.sv
// Data memory behind the mips_core load/store port: combinational loads, a one-entry
// posted write buffer with byte-lane forwarding, range check. Optional MEM_STATS_EN adds counters.
module mips_data_mem #(
    parameter logic [31:0] data_start  = 32'h1000_0000,
    parameter int          depth_words = 1024
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [29:0] mem_addr,
    input  logic [31:0] mem_data_in,
    input  logic [3:0]  mem_write_en,
    input  logic        mem_rd_en,
    input  logic        halted,
    output logic [31:0] mem_data_out,
    output logic        mem_excpt,
    output logic        wbuf_valid
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int          IDX_W    = $clog2(depth_words);
    localparam logic [32:0] LO_BOUND = {1'b0, data_start};
    localparam logic [32:0] HI_BOUND = LO_BOUND + 33'(4 * depth_words);

    logic [32:0]      w_byte_addr;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_store;
    logic             w_accept;
    logic [31:0]      w_rd_word;

    logic             r_wbuf_valid;
    logic [IDX_W-1:0] r_wbuf_idx;
    logic [31:0]      r_wbuf_data;
    logic [3:0]       r_wbuf_mask;
    logic [31:0]      r_mem [depth_words];

    // 33-bit compare keeps the upper bound from wrapping near the top of the address space.
    assign w_byte_addr = {1'b0, mem_addr, 2'b00};
    assign w_in_range  = (w_byte_addr >= LO_BOUND) && (w_byte_addr < HI_BOUND);
    assign w_idx       = IDX_W'(mem_addr - data_start[31:2]);
    assign w_store     = |mem_write_en;
    assign w_accept    = w_store & w_in_range & ~halted;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wbuf_valid <= 1'b0;
            r_wbuf_idx   <= '0;
            r_wbuf_data  <= '0;
            r_wbuf_mask  <= '0;
        end else begin
            r_wbuf_valid <= w_accept;
            if (w_accept) begin
                r_wbuf_idx  <= w_idx;
                r_wbuf_data <= mem_data_in;
                r_wbuf_mask <= mem_write_en;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto RAM; a pending store is lost on reset
    // because the async clear of r_wbuf_valid gates the drain.
    always_ff @(posedge clk) begin
        if (r_wbuf_valid) begin
            if (r_wbuf_mask[0]) r_mem[r_wbuf_idx][7:0]   <= r_wbuf_data[7:0];
            if (r_wbuf_mask[1]) r_mem[r_wbuf_idx][15:8]  <= r_wbuf_data[15:8];
            if (r_wbuf_mask[2]) r_mem[r_wbuf_idx][23:16] <= r_wbuf_data[23:16];
            if (r_wbuf_mask[3]) r_mem[r_wbuf_idx][31:24] <= r_wbuf_data[31:24];
        end
    end

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_rd_word = r_mem[w_idx];
        if (r_wbuf_valid && (r_wbuf_idx == w_idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wbuf_mask[i]) w_rd_word[8*i +: 8] = r_wbuf_data[8*i +: 8];
            end
        end
        if (!w_in_range) w_rd_word = '0;
    end

    assign mem_data_out = w_rd_word;
    assign mem_excpt    = ~w_in_range & (mem_rd_en | w_store);
    assign wbuf_valid   = r_wbuf_valid;

`ifdef MEM_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else begin
            if (mem_rd_en && w_in_range && (r_rd_count != 32'hFFFF_FFFF))
                r_rd_count <= r_rd_count + 32'd1;
            if (w_accept && (r_wr_count != 32'hFFFF_FFFF))
                r_wr_count <= r_wr_count + 32'd1;
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_mips_data_mem.sv
// Self-checking bench for mips_data_mem: directed vector table, hand sequences for reset
// and counters, and randomized traffic against a buffer-free word-array model.
module tb_mips_data_mem;

    localparam logic [31:0] DATA_START = 32'h1000_0000;
    localparam int          DEPTH      = 1024;
    localparam logic [29:0] BASE       = 30'h0400_0000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [29:0] mem_addr;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_write_en;
    logic        mem_rd_en;
    logic        halted;
    logic [31:0] mem_data_out;
    logic        mem_excpt;
    logic        wbuf_valid;
`ifdef MEM_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
`endif

    mips_data_mem #(
        .data_start  (DATA_START),
        .depth_words (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .mem_rd_en    (mem_rd_en),
        .halted       (halted),
        .mem_data_out (mem_data_out),
        .mem_excpt    (mem_excpt),
        .wbuf_valid   (wbuf_valid)
`ifdef MEM_STATS_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  we;
        logic        rd;
        logic        halt;
        logic [31:0] exp_out;
        logic        exp_exc;
        logic        exp_wbv;
    } vec_t;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] m_rd_cnt;
    logic [31:0] m_wr_cnt;
    int          n_pass;
    int          n_total;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic bit in_rng(input logic [29:0] a);
        longint ba;
        ba = longint'(a) * 4;
        return (ba >= longint'(DATA_START)) && (ba < longint'(DATA_START) + 4 * DEPTH);
    endfunction

    function automatic int idx_of(input logic [29:0] a);
        return int'((longint'(a) * 4 - longint'(DATA_START)) / 4);
    endfunction

    function automatic logic [31:0] fill_val(input int i);
        return {16'hC0DE, 16'(i)};
    endfunction

    function automatic logic [31:0] expect_rd(input logic [29:0] a);
        return in_rng(a) ? model_mem[idx_of(a)] : 32'h0;
    endfunction

    function automatic vec_t mkv(input logic [29:0] a, input logic [31:0] d, input logic [3:0] we,
                                 input logic rd, input logic h, input logic [31:0] eo,
                                 input logic ee, input logic ew);
        vec_t v;
        v.addr = a; v.data = d; v.we = we; v.rd = rd; v.halt = h;
        v.exp_out = eo; v.exp_exc = ee; v.exp_wbv = ew;
        return v;
    endfunction

    // One bus cycle: drive at negedge, sample combinational outputs, cross the edge,
    // sample wbuf_valid, then apply the cycle's effect to the model (visible from next cycle).
    task automatic step(input logic [29:0] a, input logic [31:0] d, input logic [3:0] we,
                        input logic rd, input logic h,
                        output logic [31:0] out, output logic exc, output logic wbv);
        int k;
        @(negedge clk);
        mem_addr = a; mem_data_in = d; mem_write_en = we; mem_rd_en = rd; halted = h;
        #1;
        out = mem_data_out;
        exc = mem_excpt;
        @(posedge clk);
        #1;
        wbv = wbuf_valid;
        mem_write_en = 4'h0;
        mem_rd_en    = 1'b0;
        if (in_rng(a)) begin
            k = idx_of(a);
            if (|we && !h) begin
                for (int i = 0; i < 4; i++)
                    if (we[i]) model_mem[k][8*i +: 8] = d[8*i +: 8];
                if (m_wr_cnt != 32'hFFFF_FFFF) m_wr_cnt++;
            end
            if (rd && m_rd_cnt != 32'hFFFF_FFFF) m_rd_cnt++;
        end
    endtask

    initial begin
        vec_t        vecs[$];
        logic [31:0] out;
        logic        exc;
        logic        wbv;
        logic [31:0] saved;
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  we;
        logic        rd;
        logic        h;
        logic [31:0] e_out;
        logic        e_exc;
        logic        e_wbv;
        int          r;

        n_pass = 0; n_total = 0;
        m_rd_cnt = 0; m_wr_cnt = 0;
        rst_b = 1'b0;
        mem_addr = BASE; mem_data_in = 0; mem_write_en = 0; mem_rd_en = 0; halted = 0;

        #1;
        check("reset wbuf_valid", {31'd0, wbuf_valid}, 32'd0);
        check("reset idle excpt", {31'd0, mem_excpt}, 32'd0);
`ifdef MEM_STATS_EN
        check("reset rd_count", rd_count, 32'd0);
        check("reset wr_count", wr_count, 32'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        // Give every word a known value so later expectations are fully defined.
        for (int i = 0; i < DEPTH; i++)
            step(BASE + 30'(i), fill_val(i), 4'hF, 1'b0, 1'b0, out, exc, wbv);
        check("fill wbuf_valid", {31'd0, wbv}, 32'd1);

        // Directed table. A=idx4 (0x10000010), B=idx8, C=idx12.
        vecs.push_back(mkv(BASE + 4,  32'hDEADBEEF, 4'hF, 0, 0, fill_val(4),  0, 1));
        vecs.push_back(mkv(BASE + 4,  32'h0,        4'h0, 1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkv(BASE + 4,  32'h0,        4'h0, 1, 0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkv(BASE + 8,  32'h11223344, 4'hF, 0, 0, fill_val(8),  0, 1));
        vecs.push_back(mkv(BASE + 8,  32'hAABBCCDD, 4'h5, 1, 0, 32'h11223344, 0, 1));
        vecs.push_back(mkv(BASE + 8,  32'h0,        4'h0, 1, 0, 32'h11BB33DD, 0, 0));
        vecs.push_back(mkv(BASE + 8,  32'h0,        4'h0, 1, 0, 32'h11BB33DD, 0, 0));
        vecs.push_back(mkv(BASE + 12, 32'h000000AA, 4'h1, 0, 0, fill_val(12), 0, 1));
        vecs.push_back(mkv(BASE + 12, 32'h0000BB00, 4'h2, 0, 0, 32'hC0DE00AA, 0, 1));
        vecs.push_back(mkv(BASE + 12, 32'h0,        4'h0, 1, 0, 32'hC0DEBBAA, 0, 0));
        vecs.push_back(mkv(30'h03FF_FFFF, 32'h0,    4'h0, 1, 0, 32'h0,        1, 0));
        vecs.push_back(mkv(30'h0400_0400, 32'h0,    4'h0, 1, 0, 32'h0,        1, 0));
        vecs.push_back(mkv(30'h03FF_FFFF, 32'h0,    4'h0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkv(30'h0400_0400, 32'h0,    4'h0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkv(30'h03FF_FFFF, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0,    1, 0));
        vecs.push_back(mkv(BASE + 4,  32'h12345678, 4'hF, 0, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkv(BASE + 4,  32'h0,        4'h0, 1, 1, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mkv(BASE,      32'h0,        4'h0, 1, 0, fill_val(0),  0, 0));
        vecs.push_back(mkv(BASE + 30'(DEPTH - 1), 32'h0, 4'h0, 1, 0, fill_val(DEPTH - 1), 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].addr, vecs[i].data, vecs[i].we, vecs[i].rd, vecs[i].halt, out, exc, wbv);
            check($sformatf("vec%0d data_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d excpt", i), {31'd0, exc}, {31'd0, vecs[i].exp_exc});
            check($sformatf("vec%0d wbuf_valid", i), {31'd0, wbv}, {31'd0, vecs[i].exp_wbv});
        end

        // Reset while a store sits in the buffer: the store is lost.
        saved = model_mem[20];
        step(BASE + 20, 32'hFEEDF00D, 4'hF, 1'b0, 1'b0, out, exc, wbv);
        check("pending store wbuf_valid", {31'd0, wbv}, 32'd1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("async reset wbuf_valid", {31'd0, wbuf_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        model_mem[20] = saved;
        m_rd_cnt = 0;
        m_wr_cnt = 0;

`ifdef MEM_STATS_EN
        step(BASE + 1, 32'h0, 4'h0, 1'b1, 1'b0, out, exc, wbv);
        step(BASE + 2, 32'h0, 4'h0, 1'b1, 1'b0, out, exc, wbv);
        step(BASE + 3, 32'h0, 4'h0, 1'b1, 1'b0, out, exc, wbv);
        step(BASE + 5, 32'h01020304, 4'hF, 1'b0, 1'b0, out, exc, wbv);
        step(BASE + 6, 32'h05060708, 4'h3, 1'b0, 1'b0, out, exc, wbv);
        step(30'h03FF_FFFF, 32'h0, 4'hF, 1'b1, 1'b0, out, exc, wbv);
        check("stats rd_count", rd_count, 32'd3);
        check("stats wr_count", wr_count, 32'd2);
        @(negedge clk);
        force dut.r_rd_count = 32'hFFFF_FFFF;
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_rd_count;
        release dut.r_wr_count;
        m_rd_cnt = 32'hFFFF_FFFF;
        m_wr_cnt = 32'hFFFF_FFFF;
        step(BASE + 7, 32'h0A0B0C0D, 4'hF, 1'b1, 1'b0, out, exc, wbv);
        check("saturated rd_count", rd_count, 32'hFFFF_FFFF);
        check("saturated wr_count", wr_count, 32'hFFFF_FFFF);
`endif

        step(BASE + 20, 32'h0, 4'h0, 1'b1, 1'b0, out, exc, wbv);
        check("reset dropped store", out, saved);

        // Randomized traffic concentrated on a few words so forwarding and merges collide often.
        for (int n = 0; n < 2000; n++) begin
            r = $urandom_range(0, 99);
            if (r < 80)      a = BASE + 30'($urandom_range(0, 15));
            else if (r < 87) a = BASE - 30'($urandom_range(1, 8));
            else if (r < 93) a = BASE + 30'(DEPTH) + 30'($urandom_range(0, 7));
            else if (r < 97) a = BASE + 30'(DEPTH) - 30'($urandom_range(1, 4));
            else             a = 30'($urandom);
            d  = $urandom;
            we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            rd = 1'($urandom_range(0, 1));
            h  = ($urandom_range(0, 9) == 0);
            e_out = expect_rd(a);
            e_exc = !in_rng(a) && (rd || (|we));
            e_wbv = in_rng(a) && (|we) && !h;
            step(a, d, we, rd, h, out, exc, wbv);
            check($sformatf("rand%0d data_out", n), out, e_out);
            check($sformatf("rand%0d excpt", n), {31'd0, exc}, {31'd0, e_exc});
            check($sformatf("rand%0d wbuf_valid", n), {31'd0, wbv}, {31'd0, e_wbv});
        end

`ifdef MEM_STATS_EN
        check("final rd_count", rd_count, m_rd_cnt);
        check("final wr_count", wr_count, m_wr_cnt);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
